// File: rtl/apb3_master_pkg.sv
// Shared types and round-robin helper for the APB3 round-robin master.
// State encoding, requester limit and next-grant search.
package apb3_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam int MAX_REQ = 8;
  localparam int MAX_IW  = 3;

  // Searches upward from last+1; the last grantee has lowest priority.
  function automatic logic [MAX_IW-1:0] rr_next(
    input logic [MAX_REQ-1:0] req,
    input logic [MAX_IW-1:0]  last,
    input int                 n
  );
    int j;
    rr_next = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % n;
      if (k <= n && req[j[MAX_IW-1:0]])
        rr_next = j[MAX_IW-1:0];
    end
  endfunction

endpackage

// File: rtl/apb3_rr_master_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index.
// Grants nothing while disabled or when no request is pending.
module rr_arbiter
  import apb3_master_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  input  logic                 en_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  logic [MAX_IW-1:0] idx;

  assign idx   = rr_next(MAX_REQ'(req_i), MAX_IW'(last_i), N);
  assign idx_o = IW'(idx);
  assign gnt_o = (en_i && |req_i) ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/apb3_rr_master.sv
// Round-robin APB3 master sharing one slave port among NUM_REQ requesters.
// Define APB3_RR_MASTER_TIMEOUT_EN to abort hung ACCESS phases.
module apb3_rr_master
  import apb3_master_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic                          PREADY,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PSLVERROR
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_n
    $error("NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e                state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  psel_q, psel_d;
  logic                  pen_q, pen_d;
  logic [NUM_REQ-1:0]    rspv_q, rspv_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gidx_arb;
  logic                  timeout;

`ifdef APB3_RR_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP)
      cnt_d = '0;
    else if (state_q == ACCESS && !PREADY)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // This cycle would be the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  assign timeout = (state_q == ACCESS) && !PREADY &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .en_i   (state_q == IDLE),
    .gnt_o  (gnt),
    .idx_o  (gidx_arb)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gidx_d  = gidx_arb;
          addr_d  = req_addr[int'(gidx_arb)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(gidx_arb)*DATA_WIDTH +: DATA_WIDTH];
          write_d = req_write[gidx_arb];
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rdata_d = write_q ? '0 : PRDATA;
          err_d   = PSLVERROR;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = gidx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    psel_d = (state_d == SETUP) || (state_d == ACCESS);
    pen_d  = (state_d == ACCESS);
    rspv_d = (state_d == RESP) ? (NUM_REQ'(1) << gidx_d) : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      psel_q  <= 1'b0;
      pen_q   <= 1'b0;
      rspv_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      psel_q  <= psel_d;
      pen_q   <= pen_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rspv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PADDR     = addr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = pen_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;

endmodule

// File: tb/tb_apb3_rr_master.sv
// Directed bench for apb3_rr_master: vector table plus handwritten
// fairness, reset and (with APB3_RR_MASTER_TIMEOUT_EN) timeout sequences.
module tb_apb3_rr_master;

  logic        clk;
  logic        resetn;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_write;
  logic [47:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERROR;

  int n_chk;
  int n_fail;

  apb3_rr_master #(
    .NUM_REQ        (3),
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERROR (PSLVERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [2:0] oh;
    oh = 3'b001 << v.r;
    req_write = '0;
    req_write[v.r] = v.wr;
    req_addr[v.r*16 +: 16] = v.addr;
    req_wdata[v.r*32 +: 32] = v.wdata;
    PRDATA = v.prdata;
    PSLVERROR = v.slverr;
    PREADY = 1'b0;
    req_valid = oh;
    @(negedge clk);
    check("accept_ready", req_ready, oh);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("setup_sel_en", {PSEL, PENABLE}, 2'b10);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.wr);
    if (v.wr) check("setup_pwdata", PWDATA, v.wdata);
    for (int w = 0; w <= v.waits; w++) begin
      @(posedge clk);
      #1 PREADY = (w == v.waits);
      @(negedge clk);
      check("access_sel_en", {PSEL, PENABLE}, 2'b11);
      check("access_paddr", PADDR, v.addr);
      if (v.wr) check("access_pwdata", PWDATA, v.wdata);
      check("access_no_rsp", rsp_valid, 3'b000);
    end
    @(posedge clk);
    #1 PREADY = 1'b0;
    @(negedge clk);
    check("resp_valid", rsp_valid, oh);
    check("resp_rdata", rsp_rdata, v.exp_rdata);
    check("resp_err", rsp_err, v.exp_err);
    check("resp_sel", {PSEL, PENABLE}, 2'b00);
    @(negedge clk);
    check("idle_no_rsp", rsp_valid, 3'b000);
    check("idle_rdata_hold", rsp_rdata, v.exp_rdata);
    check("idle_paddr_hold", PADDR, v.addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] r;
    logic [2:0] exp;
    int cnt;
    n_chk = 0;
    n_fail = 0;

    tbl[0] = '{1, 1'b0, 16'h0014, 32'h0, 0, 32'hDEADBEEF, 1'b0,
               32'hDEADBEEF, 1'b0};
    tbl[1] = '{0, 1'b1, 16'h0008, 32'h12345678, 2, 32'hA5A5A5A5, 1'b0,
               32'h0, 1'b0};
    tbl[2] = '{2, 1'b0, 16'h0100, 32'h0, 1, 32'h0BADF00D, 1'b1,
               32'h0BADF00D, 1'b1};
    tbl[3] = '{2, 1'b0, 16'h0104, 32'h0, 0, 32'h11223344, 1'b0,
               32'h11223344, 1'b0};
    tbl[4] = '{1, 1'b1, 16'hFFFC, 32'hCAFEF00D, 0, 32'h77777777, 1'b1,
               32'h0, 1'b1};
    tbl[5] = '{0, 1'b0, 16'h0000, 32'h0, 3, 32'h55AA55AA, 1'b0,
               32'h55AA55AA, 1'b0};

    resetn = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    PREADY = 1'b0;
    PRDATA = '0;
    PSLVERROR = 1'b0;
    #3;
    check("rst_sel_en", {PSEL, PENABLE}, 2'b00);
    check("rst_rsp_valid", rsp_valid, 3'b000);
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_paddr", PADDR, 16'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Fairness with all requesters continuously valid
    for (int i = 0; i < 3; i++)
      req_addr[i*16 +: 16] = 16'h0100 + 16'(i * 4);
    PREADY = 1'b1;
    PRDATA = 32'h600D0000;
    req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp = 3'b001 << (t % 3);
      r = '0;
      for (int k = 0; k < 20 && r == '0; k++) begin
        @(negedge clk);
        r = req_ready;
      end
      check("fair_grant", r, exp);
      r = '0;
      for (int k = 0; k < 20 && r == '0; k++) begin
        @(negedge clk);
        r = rsp_valid;
      end
      check("fair_rsp", r, exp);
    end
    @(posedge clk);
    #1 req_valid = '0;
    PREADY = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i]);

    // Reset while ACCESS is stalled
    req_write = '0;
    req_addr[16 +: 16] = 16'h0200;
    req_valid = 3'b010;
    @(negedge clk);
    check("mid_rst_grant", req_ready, 3'b010);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_sel_en", {PSEL, PENABLE}, 2'b00);
    PREADY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid, 3'b000);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    PREADY = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    check("post_rst_grant", req_ready, 3'b001);
    check("post_rst_no_rsp", rsp_valid, 3'b000);
    @(posedge clk);
    #1 req_valid = '0;
    PREADY = 1'b1;
    r = '0;
    for (int k = 0; k < 20 && r == '0; k++) begin
      @(negedge clk);
      r = rsp_valid;
    end
    check("post_rst_rsp", r, 3'b001);
    @(posedge clk);
    #1 PREADY = 1'b0;
    @(posedge clk);
    #1;

`ifdef APB3_RR_MASTER_TIMEOUT_EN
    req_write = '0;
    req_addr[0 +: 16] = 16'h0040;
    PRDATA = 32'hFFFFFFFF;
    PREADY = 1'b0;
    req_valid = 3'b001;
    @(negedge clk);
    check("to_grant", req_ready, 3'b001);
    @(posedge clk);
    #1 req_valid = '0;
    cnt = 0;
    r = '0;
    for (int k = 0; k < 20 && r == '0; k++) begin
      @(negedge clk);
      if (PENABLE) cnt++;
      r = rsp_valid;
    end
    check("to_access_cycles", cnt, 4);
    check("to_rsp_valid", r, 3'b001);
    check("to_err", rsp_err, 1'b1);
    check("to_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    check("to_idle_sel", {PSEL, PENABLE}, 2'b00);
    check("to_idle_rsp", rsp_valid, 3'b000);
    @(posedge clk);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
